// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-search sequencer and its S-RAM mux.
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_JUDGE,
    ST_FOUND,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    OWN_INIT,
    OWN_KSA,
    OWN_DEC
  } owner_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
  } sram_req_t;

  // Registered handshake and status outputs, kept together so they share one register.
  typedef struct packed {
    logic init_start;
    logic ksa_start;
    logic dec_start;
    logic init_ack;
    logic ksa_ack;
    logic dec_ack;
    logic busy;
    logic found;
    logic fail;
  } ctl_t;

  function automatic logic is_plain_char(input logic [7:0] c);
    return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/rc4_sram_mux.sv
// Owner-selected 3:1 mux onto the single-port S working RAM.
module rc4_sram_mux
  import rc4_pkg::*;
(
  input  owner_e    owner_i,
  input  logic      en_i,
  input  sram_req_t init_i,
  input  sram_req_t ksa_i,
  input  sram_req_t dec_i,
  output sram_req_t s_o
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    s_o = '0;
    case (owner_i)
      OWN_INIT: s_o = init_i;
      OWN_KSA:  s_o = ksa_i;
      OWN_DEC:  s_o = dec_i;
      default:  s_o = '0;
    endcase
    if (!en_i) s_o.wren = 1'b0;
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Per-key sequencer: S init, KSA, decrypt; snoops plaintext writes and stops on found or exhausted keys.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   MSG_LEN   = MSG_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 found,
  output logic                 fail,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 dec_start,
  input  logic                 init_finish,
  input  logic                 ksa_finish,
  input  logic                 dec_finish,
  output logic                 init_ack,
  output logic                 ksa_ack,
  output logic                 dec_ack,
  input  logic [7:0]           init_addr,
  input  logic [7:0]           ksa_addr,
  input  logic [7:0]           dec_addr,
  input  logic [7:0]           init_data,
  input  logic [7:0]           ksa_data,
  input  logic [7:0]           dec_data,
  input  logic                 init_wren,
  input  logic                 ksa_wren,
  input  logic                 dec_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  input  logic                 d_wren,
  input  logic [7:0]           d_data
);

  localparam int WCNT_W = $clog2(MSG_LEN + 2);
  localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(MSG_LEN);
  localparam logic [WCNT_W-1:0] WCNT_SAT  = WCNT_W'(MSG_LEN + 1);

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 bad_q, bad_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  ctl_t                 ctl_q, ctl_d;
  logic                 msg_ok;
  sram_req_t            s_req;

  assign msg_ok = !bad_q && (wcnt_q == WCNT_FULL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // WAIT states linger one extra cycle while the ack is out, so the next start never meets it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_FAIL: if (start) state_d = ST_INIT_GO;
      ST_INIT_GO:   state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: if (ctl_q.init_ack) state_d = ST_KSA_GO;
      ST_KSA_GO:    state_d = ST_KSA_WAIT;
      ST_KSA_WAIT:  if (ctl_q.ksa_ack) state_d = ST_DEC_GO;
      ST_DEC_GO:    state_d = ST_DEC_WAIT;
      ST_DEC_WAIT:  if (ctl_q.dec_ack) state_d = ST_JUDGE;
      ST_JUDGE: begin
        if (msg_ok)                state_d = ST_FOUND;
        else if (key_q == KEY_LAST) state_d = ST_FAIL;
        else                       state_d = ST_INIT_GO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_d            = '0;
    ctl_d.init_start = (state_d == ST_INIT_GO);
    ctl_d.ksa_start  = (state_d == ST_KSA_GO);
    ctl_d.dec_start  = (state_d == ST_DEC_GO);
    ctl_d.init_ack   = (state_q == ST_INIT_WAIT) && (owner_q == OWN_INIT) && init_finish && !ctl_q.init_ack;
    ctl_d.ksa_ack    = (state_q == ST_KSA_WAIT)  && (owner_q == OWN_KSA)  && ksa_finish  && !ctl_q.ksa_ack;
    ctl_d.dec_ack    = (state_q == ST_DEC_WAIT)  && (owner_q == OWN_DEC)  && dec_finish  && !ctl_q.dec_ack;
    ctl_d.found      = (state_d == ST_FOUND);
    ctl_d.fail       = (state_d == ST_FAIL);
    ctl_d.busy       = !((state_d == ST_IDLE) || (state_d == ST_FOUND) || (state_d == ST_FAIL));
  end

  always_comb begin
    key_d   = key_q;
    owner_d = owner_q;
    bad_d   = bad_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_FAIL: if (start) key_d = '0;
      ST_INIT_GO: owner_d = OWN_INIT;
      ST_KSA_GO:  owner_d = OWN_KSA;
      ST_DEC_GO: begin
        owner_d = OWN_DEC;
        bad_d   = 1'b0;
        wcnt_d  = '0;
      end
      ST_DEC_WAIT: begin
        if (d_wren) begin
          if (wcnt_q != WCNT_SAT)  wcnt_d = wcnt_q + WCNT_W'(1);
          if (!is_plain_char(d_data)) bad_d = 1'b1;
        end
      end
      ST_JUDGE: if (!msg_ok && (key_q != KEY_LAST)) key_d = key_q + KEY_WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      owner_q <= OWN_INIT;
      bad_q   <= 1'b0;
      wcnt_q  <= '0;
      ctl_q   <= '0;
    end else begin
      key_q   <= key_d;
      owner_q <= owner_d;
      bad_q   <= bad_d;
      wcnt_q  <= wcnt_d;
      ctl_q   <= ctl_d;
    end
  end

  rc4_sram_mux u_sram_mux (
    .owner_i (owner_q),
    .en_i    (ctl_q.busy),
    .init_i  ('{addr: init_addr, data: init_data, wren: init_wren}),
    .ksa_i   ('{addr: ksa_addr,  data: ksa_data,  wren: ksa_wren}),
    .dec_i   ('{addr: dec_addr,  data: dec_data,  wren: dec_wren}),
    .s_o     (s_req)
  );

  assign s_addr     = s_req.addr;
  assign s_data     = s_req.data;
  assign s_wren     = s_req.wren;
  assign key        = key_q;
  assign busy       = ctl_q.busy;
  assign found      = ctl_q.found;
  assign fail       = ctl_q.fail;
  assign init_start = ctl_q.init_start;
  assign ksa_start  = ctl_q.ksa_start;
  assign dec_start  = ctl_q.dec_start;
  assign init_ack   = ctl_q.init_ack;
  assign ksa_ack    = ctl_q.ksa_ack;
  assign dec_ack    = ctl_q.dec_ack;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: stub engines, per-key message plans and a first-valid-key model.
module tb_rc4_key_search_ctrl;

  localparam int              KW     = 24;
  localparam logic [KW-1:0]   KLAST  = 24'd3;
  localparam int              NKEYS  = 4;
  localparam int              MAXLEN = 40;

  logic clk = 1'b0;
  logic rst, start;
  logic [KW-1:0] key;
  logic busy, found, fail;
  logic init_start, ksa_start, dec_start;
  logic init_ack, ksa_ack, dec_ack;
  logic init_finish, ksa_finish, dec_finish;
  logic [7:0] init_addr, ksa_addr, dec_addr, init_data, ksa_data, dec_data;
  logic init_wren, ksa_wren, dec_wren;
  logic [7:0] s_addr, s_data;
  logic s_wren, d_wren;
  logic [7:0] d_data;

  // Init stub state; rogue makes the init engine misbehave while it does not own the RAM.
  logic ifin, iwren, rogue;
  logic [7:0] iaddr;
  assign init_finish = ifin | rogue;
  assign init_wren   = iwren | rogue;
  assign init_addr   = rogue ? 8'hAA : iaddr;
  assign init_data   = rogue ? 8'h55 : (iaddr ^ 8'h0F);

  logic [7:0] plan_b [NKEYS][MAXLEN];
  int         plan_len [NKEYS];

  int n_vec = 0, n_err = 0;
  int n_is = 0, n_ks = 0, n_ds = 0, n_ia = 0, n_ka = 0, n_da = 0;
  logic consec = 1'b0;

  rc4_key_search_ctrl #(.KEY_WIDTH(KW), .KEY_LAST(KLAST), .MSG_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy), .found(found), .fail(fail),
    .init_start(init_start), .ksa_start(ksa_start), .dec_start(dec_start),
    .init_finish(init_finish), .ksa_finish(ksa_finish), .dec_finish(dec_finish),
    .init_ack(init_ack), .ksa_ack(ksa_ack), .dec_ack(dec_ack),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .dec_addr(dec_addr),
    .init_data(init_data), .ksa_data(ksa_data), .dec_data(dec_data),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .d_wren(d_wren), .d_data(d_data)
  );

  always #5 clk = ~clk;

  // Engine stubs act on the falling edge; the DUT samples on the rising edge.
  initial begin : init_stub
    int cnt;
    cnt = 0; ifin = 0; iwren = 0; iaddr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; ifin = 0; iwren = 0;
      end else begin
        if (init_ack) ifin = 0;
        if (init_start) cnt = 3;
        else if (cnt > 0) begin
          iwren = 1; iaddr = iaddr + 8'd1; cnt--;
          if (cnt == 0) ifin = 1;
        end else iwren = 0;
      end
    end
  end

  initial begin : ksa_stub
    int cnt;
    cnt = 0; ksa_finish = 0; ksa_wren = 0; ksa_addr = 0; ksa_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; ksa_finish = 0; ksa_wren = 0;
      end else begin
        if (ksa_ack) ksa_finish = 0;
        if (ksa_start) cnt = 3;
        else if (cnt > 0) begin
          ksa_wren = 1; ksa_addr = ksa_addr + 8'd3; ksa_data = ksa_addr ^ 8'hC3; cnt--;
          if (cnt == 0) ksa_finish = 1;
        end else ksa_wren = 0;
      end
    end
  end

  // Decrypt stub plays back the plan for the current key; the last write shares its cycle with finish.
  initial begin : dec_stub
    int pos, len, k;
    bit active;
    active = 0; pos = 0; len = 0; k = 0;
    dec_finish = 0; dec_wren = 0; dec_addr = 0; dec_data = 0; d_wren = 0; d_data = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; dec_finish = 0; dec_wren = 0; d_wren = 0;
      end else begin
        if (dec_ack) dec_finish = 0;
        if (dec_start) begin
          active = 1; pos = 0; k = int'(key[1:0]); len = plan_len[k];
          dec_wren = 0; d_wren = 0;
        end else if (active) begin
          d_data = plan_b[k][pos]; d_wren = 1;
          dec_wren = 1; dec_addr = 8'(pos); dec_data = ~d_data;
          pos++;
          if (pos == len) begin dec_finish = 1; active = 0; end
        end else begin
          d_wren = 0; dec_wren = 0;
        end
      end
    end
  end

  initial begin : pulse_monitor
    logic [5:0] cur, prev;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {init_start, ksa_start, dec_start, init_ack, ksa_ack, dec_ack};
      if ((cur & prev) != 6'b0) consec = 1'b1;
      n_is += int'(cur[5]); n_ks += int'(cur[4]); n_ds += int'(cur[3]);
      n_ia += int'(cur[2]); n_ka += int'(cur[1]); n_da += int'(cur[0]);
      prev = cur;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic fill_all(input int len, input logic [7:0] b);
    for (int i = 0; i < NKEYS; i++) begin
      plan_len[i] = len;
      for (int j = 0; j < MAXLEN; j++) plan_b[i][j] = b;
    end
  endtask

  task automatic fill_random();
    int lens [5] = '{31, 32, 32, 32, 33};
    int r;
    for (int i = 0; i < NKEYS; i++) begin
      plan_len[i] = lens[$urandom_range(0, 4)];
      for (int j = 0; j < MAXLEN; j++) begin
        r = $urandom_range(0, 26);
        plan_b[i][j] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
      if ($urandom_range(0, 2) == 0) plan_b[i][$urandom_range(0, 30)] = 8'($urandom_range(0, 255));
    end
  endtask

  // Reference: the search reports the first key whose message is exactly 32 plain characters.
  function automatic void model(output bit f, output int k);
    bit ok;
    f = 0;
    k = int'(KLAST);
    for (int i = 0; i < NKEYS; i++) begin
      ok = (plan_len[i] == 32);
      for (int j = 0; j < plan_len[i]; j++)
        if (!(plan_b[i][j] == " " || (plan_b[i][j] >= "a" && plan_b[i][j] <= "z"))) ok = 0;
      if (ok) begin f = 1; k = i; return; end
    end
  endfunction

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 3000 && !(found || fail); i++) tick();
    check({tag, "_done"}, 32'(found | fail), 1);
  endtask

  task automatic check_result(input string tag, input int is0, ks0, ds0, ia0, ka0, da0);
    bit ef;
    int ek, np;
    model(ef, ek);
    np = ek + 1;
    check({tag, "_found"}, 32'(found), 32'(ef));
    check({tag, "_fail"},  32'(fail),  32'(!ef));
    check({tag, "_key"},   32'(key),   32'(ek));
    check({tag, "_busy"},  32'(busy),  0);
    check({tag, "_n_init_start"}, n_is - is0, np);
    check({tag, "_n_ksa_start"},  n_ks - ks0, np);
    check({tag, "_n_dec_start"},  n_ds - ds0, np);
    check({tag, "_n_init_ack"},   n_ia - ia0, np);
    check({tag, "_n_ksa_ack"},    n_ka - ka0, np);
    check({tag, "_n_dec_ack"},    n_da - da0, np);
    check({tag, "_no_double_pulse"}, 32'(consec), 0);
  endtask

  task automatic run_search(input string tag);
    int is0, ks0, ds0, ia0, ka0, da0;
    is0 = n_is; ks0 = n_ks; ds0 = n_ds; ia0 = n_ia; ka0 = n_ka; da0 = n_da;
    pulse_start();
    wait_end(tag);
    check_result(tag, is0, ks0, ds0, ia0, ka0, da0);
  endtask

  initial begin : main
    int is0, ks0, ds0, ia0, ka0, da0;
    rst = 1; start = 0; rogue = 0;
    fill_all(32, "a");
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_found", 32'(found), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_key", 32'(key), 0);
    check("rst_starts", {29'd0, init_start, ksa_start, dec_start}, 0);
    check("rst_acks", {29'd0, init_ack, ksa_ack, dec_ack}, 0);
    check("rst_s_wren", 32'(s_wren), 0);
    rst = 0;
    tick();
    check("idle_busy", 32'(busy), 0);

    // Reset while the KSA stub of key 1 is running.
    fill_all(32, "a");
    plan_b[0][7] = "A";
    pulse_start();
    for (int i = 0; i < 500 && !(ksa_start && key == 24'd1); i++) tick();
    check("midksa_reached", {31'd0, ksa_start && key == 24'd1}, 1);
    tick();
    rst = 1;
    #1;
    check("midksa_busy", 32'(busy), 0);
    check("midksa_key", 32'(key), 0);
    check("midksa_flags", {26'd0, found, fail, init_start, ksa_start, dec_start, ksa_ack}, 0);
    tick();
    check("midksa_s_wren", 32'(s_wren), 0);
    rst = 0;
    repeat (3) tick();
    check("midksa_idle", 32'(busy), 0);

    fill_all(32, "a");
    run_search("all_a");

    fill_all(32, "a");
    for (int i = 0; i < 3; i++) plan_b[i][5] = "A";
    run_search("upper_first3");

    fill_all(32, 8'h7B);
    run_search("all_brace");
    is0 = n_is;
    repeat (20) tick();
    check("fail_no_more_start", n_is - is0, 0);
    check("fail_held", {30'd0, fail, busy}, 2);

    fill_all(32, "a");
    plan_len[0] = 31;
    run_search("short31");

    fill_all(32, "a");
    plan_len[0] = 33;
    run_search("long33");

    fill_all(32, "z");
    plan_b[0][0]  = 8'h60;
    plan_b[1][31] = 8'h7B;
    for (int j = 0; j < 32; j += 2) plan_b[2][j] = 8'h20;
    run_search("char_edges");

    // Arbitration: init engine misbehaves while decrypt owns the RAM; start mid-run is ignored.
    fill_all(32, "a");
    is0 = n_is; ks0 = n_ks; ds0 = n_ds; ia0 = n_ia; ka0 = n_ka; da0 = n_da;
    pulse_start();
    for (int i = 0; i < 200 && !dec_start; i++) tick();
    check("arb_dec_started", 32'(dec_start), 1);
    tick(); tick();
    rogue = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start = (i == 2);
      check("arb_s_wren", 32'(s_wren), 32'(dec_wren));
      check("arb_s_addr", 32'(s_addr), 32'(dec_addr));
      check("arb_s_data", 32'(s_data), 32'(dec_data));
    end
    start = 0;
    rogue = 0;
    check("arb_key_kept", 32'(key), 0);
    wait_end("arb");
    check_result("arb", is0, ks0, ds0, ia0, ka0, da0);

    rogue = 1;
    ia0 = n_ia;
    tick();
    check("found_s_wren", 32'(s_wren), 0);
    repeat (4) tick();
    check("found_no_rogue_ack", n_ia - ia0, 0);
    check("found_hold", 32'(found), 1);
    rogue = 0;
    tick();

    for (int r = 0; r < 8; r++) begin
      fill_random();
      run_search($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
